// File: rtl/interrupt_sequencer_if.sv
// Pipeline-side bundle for the interrupt sequencer.
// slave: the sequencer itself. master: the pipeline / controller that drives
// requests, mask writes and EXE/ID status, and consumes flush and redirect.
interface interrupt_sequencer_if #(
    parameter int unsigned N_IRQ = 4
);
    // Requests and mask programming
    logic [N_IRQ-1:0] irq_in;
    logic             irq_en_wen;
    logic [N_IRQ-1:0] irq_en_wdata;

    // Pipeline status
    logic             exe_valid;
    logic [31:0]      exe_pc;
    logic             exe_in_delay_slot;
    logic             pipe_stall;
    logic             eret_id;

    // Control back into the pipeline
    logic             int_flush;
    logic             eret_flush;
    logic             pc_redirect;
    logic [31:0]      pc_target;

    // Visible state
    logic [31:0]      epc;
    logic [2:0]       irq_cause;
    logic [N_IRQ-1:0] irq_en;
    logic             in_service;

    modport slave (
        input  irq_in, irq_en_wen, irq_en_wdata,
        input  exe_valid, exe_pc, exe_in_delay_slot, pipe_stall, eret_id,
        output int_flush, eret_flush, pc_redirect, pc_target,
        output epc, irq_cause, irq_en, in_service
    );

    modport master (
        output irq_in, irq_en_wen, irq_en_wdata,
        output exe_valid, exe_pc, exe_in_delay_slot, pipe_stall, eret_id,
        input  int_flush, eret_flush, pc_redirect, pc_target,
        input  epc, irq_cause, irq_en, in_service
    );
endinterface

// File: rtl/interrupt_sequencer.sv
// External interrupt entry/return sequencer for the 5-stage MIPS pipeline.
// Synchronizes and masks the request lines, picks the lowest-index winner,
// squashes EXE and younger at a safe point, saves the restart PC and
// redirects fetch to VECTOR; ERET redirects fetch back to the saved PC.
module interrupt_sequencer #(
    parameter int unsigned N_IRQ  = 4,
    parameter logic [31:0] VECTOR = 32'h0000_0180
) (
    input logic                  clk,
    input logic                  rst,
    interrupt_sequencer_if.slave bus
);

    typedef enum logic {
        IDLE    = 1'b0,
        SERVICE = 1'b1
    } state_e;

    // Registered state
    state_e           state_q,     state_d;
    logic [N_IRQ-1:0] sync1_q,     sync1_d;
    logic [N_IRQ-1:0] sync2_q,     sync2_d;
    logic [N_IRQ-1:0] irq_en_q,    irq_en_d;
    logic [31:0]      epc_q,       epc_d;
    logic [2:0]       irq_cause_q, irq_cause_d;

    // Combinational decisions
    logic [N_IRQ-1:0] pending;
    logic [2:0]       winner;
    logic             take;
    logic             ret;
    logic [31:0]      restart_pc;
    logic             pc_redirect;
    logic [31:0]      pc_target;

    // Masked requests; only synchronized levels reach the decision logic, so
    // there is no combinational path from irq_in to any output.
    assign pending = sync2_q & irq_en_q;

    // Fixed priority: scan from the top so the lowest set index is kept.
    always_comb begin
        // NOTE: every combinationally assigned signal gets a default first so
        // no path leaves it unassigned, which would otherwise infer a latch.
        winner = '0;
        for (int i = int'(N_IRQ) - 1; i >= 0; i--) begin
            if (pending[i]) begin
                winner = 3'(i);
            end
        end
    end

    // Safe-point decisions: entry needs a real, non-stalled EXE instruction;
    // return only fires from SERVICE, which also makes ret win over pending.
    always_comb begin
        take = (state_q == IDLE) && (pending != '0) &&
               bus.exe_valid && !bus.pipe_stall;
        ret  = (state_q == SERVICE) && bus.eret_id && !bus.pipe_stall;
    end

    // Restart PC: a delay-slot victim restarts at its branch (wraps mod 2^32).
    always_comb begin
        restart_pc = bus.exe_pc;
        if (bus.exe_in_delay_slot) begin
            restart_pc = bus.exe_pc - 32'd4;
        end
    end

    // Fetch redirect: vector on entry, saved PC on return, zero otherwise.
    always_comb begin
        pc_redirect = take || ret;
        pc_target   = '0;
        if (take) begin
            pc_target = VECTOR;
        end else if (ret) begin
            pc_target = epc_q;
        end
    end

    // Next-state computation for the synchronizer, mask and FSM.
    always_comb begin
        sync1_d     = bus.irq_in;
        sync2_d     = sync1_q;
        state_d     = state_q;
        epc_d       = epc_q;
        irq_cause_d = irq_cause_q;
        // The mask is written in parallel with a take; take above already used
        // the old mask, so the new value only affects pending from next cycle.
        irq_en_d    = bus.irq_en_wen ? bus.irq_en_wdata : irq_en_q;

        unique case (state_q)
            IDLE: begin
                if (take) begin
                    epc_d       = restart_pc;
                    irq_cause_d = winner;
                    state_d     = SERVICE;
                end
            end
            SERVICE: begin
                // epc and irq_cause hold until the next take.
                if (ret) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // All state, including the FSM, registered with an asynchronous reset.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!rst) begin
            state_q     <= IDLE;
            sync1_q     <= '0;
            sync2_q     <= '0;
            irq_en_q    <= '0;
            epc_q       <= '0;
            irq_cause_q <= '0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            irq_en_q    <= irq_en_d;
            epc_q       <= epc_d;
            irq_cause_q <= irq_cause_d;
        end
    end

    // Output mapping: flush/redirect are Mealy, the rest come from flops.
    assign bus.int_flush   = take;
    assign bus.eret_flush  = ret;
    assign bus.pc_redirect = pc_redirect;
    assign bus.pc_target   = pc_target;
    assign bus.epc         = epc_q;
    assign bus.irq_cause   = irq_cause_q;
    assign bus.irq_en      = irq_en_q;
    assign bus.in_service  = (state_q == SERVICE);

endmodule

// File: doc/interrupt_sequencer.md
# interrupt_sequencer

Sequences external interrupt entry and return for the 5-stage pipelined MIPS CPU. Synchronizes and masks up to N_IRQ level-sensitive request lines and picks the winner by fixed priority. At a safe point it squashes the instruction in EXE and everything younger, saves the restart PC and redirects fetch to the handler vector. On ERET it redirects back to the saved PC. It sits beside the pipeline controller: its flush outputs are ORed into the stage resets, and its redirect overrides pc_src.

## Interface
- N_IRQ, 4: number of interrupt request lines (1..8)
- VECTOR, 32'h0000_0180: handler entry PC
- clk  in  1  main clock, rising edge
- rst  in  1  reset; asynchronous, active-low (asserted at 0)
- irq_in  in  N_IRQ  level interrupt requests, asynchronous to clk
- irq_en_wen  in  1  write strobe for mask register
- irq_en_wdata  in  N_IRQ  new mask value
- exe_valid  in  1  EXE stage holds a real instruction
- exe_pc  in  32  PC of instruction in EXE
- exe_in_delay_slot  in  1  EXE instruction is a branch/jump delay slot
- pipe_stall  in  1  load-use stall active this cycle
- eret_id  in  1  ERET decoded in ID, ID valid
- int_flush  out  1  reset IF, ID and EXE at next edge (entry)
- eret_flush  out  1  reset IF at next edge (return)
- pc_redirect  out  1  override pc_src; next PC = pc_target
- pc_target  out  32  redirect target
- epc  out  32  saved restart PC
- irq_cause  out  3  index of accepted source
- irq_en  out  N_IRQ  current mask register
- in_service  out  1  handler running; further interrupts blocked

## Operation
- Synchronizer: two flops per line, sync = irq_in delayed 2 clk. pending = sync & irq_en.
- Mask register: on irq_en_wen, irq_en <= irq_en_wdata. The new mask affects pending from the next cycle.
- Winner: the lowest-index set bit of pending.
- FSM has two states, IDLE and SERVICE. Reset puts the FSM in IDLE.
- IDLE, take = (pending != 0) & exe_valid & ~pipe_stall.
  - take drives int_flush=1, pc_redirect=1 and pc_target=VECTOR in the same cycle (Mealy).
  - At the edge: epc <= exe_in_delay_slot ? exe_pc-4 : exe_pc. The subtraction is mod 2^32.
  - At the edge: irq_cause <= winner, state <= SERVICE.
  - If take=0, stay in IDLE.
- SERVICE: in_service=1 and pending is ignored.
  - ret = eret_id & ~pipe_stall.
  - ret drives pc_redirect=1, pc_target=epc and eret_flush=1 in the same cycle, then state <= IDLE.
  - epc and irq_cause hold until the next take.
- When pc_redirect=0, pc_target=0.
- Simultaneous events:
  - ret and pending in SERVICE: ret wins. The interrupt can be taken no earlier than the cycle after return.
  - take and irq_en_wen in the same cycle: take uses the old mask.
- The victim instruction (in EXE) is squashed and re-executed after ERET. For a delay-slot victim, the branch is re-executed.
- Source deassertion: if a source drops before take, nothing happens. The block does not latch requests; the handler clears the source.

## Timing
- Reset (rst=0, asynchronous): state=IDLE, sync flops=0, irq_en=0, epc=0, irq_cause=0.
  - All outputs are 0 while in reset and immediately after release.
  - A reset mid-SERVICE returns to IDLE with epc cleared.
- Latency from an irq_in rising edge to int_flush: 2 cycles minimum (synchronizer). It extends while exe_valid=0 or pipe_stall=1.
- int_flush and pc_redirect on entry last exactly 1 cycle per take.
- eret_flush and pc_redirect on return last exactly 1 cycle per ret.
- Handler fetch begins on the cycle after int_flush.
- The first instruction of a take is fetched at VECTOR. The first instruction after return is fetched at epc.
- No combinational path from irq_in to any output.

## Test plan
- Basic entry: irq_en=4'b0001, irq_in[0] rises with exe_pc=0x40 valid and no stall.
  - Third edge after the rise: int_flush=1, pc_target=0x180.
  - Next cycle: epc=0x40, irq_cause=0, in_service=1.
- Priority and mask: irq_en=4'b1100 with irq_in=4'b1110 -> irq_cause=2.
  - With irq_en=0 instead -> no take for 20 cycles.
- Delay slot and wrap: exe_in_delay_slot=1 with exe_pc=0x24 -> epc=0x20.
  - With exe_pc=0x0 -> epc=0xFFFF_FFFC.
- Stall and bubble hold-off: pending with pipe_stall=1 for 3 cycles then exe_valid=0 for 2 cycles -> int_flush stays 0.
  - int_flush rises in the first cycle with both conditions clear.
- Return and collision: in SERVICE, eret_id=1 while irq_in[1] is high and enabled.
  - That cycle: pc_redirect=1, pc_target=epc, eret_flush=1, int_flush=0.
  - Next cycle: take for source 1.
- Async reset mid-SERVICE: drop rst for half a cycle -> in_service, epc and irq_en are 0 immediately, with no clock edge required.
